// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared state type and line constants for the USB host transmit PHY
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J,
    ST_GAP
  } tx_state_e;

  // Line states encoded as {d_p, d_n}
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam int unsigned STUFF_LIMIT = 6;

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// rtl/usb_nrzi_stuffer.sv - NRZI level and ones counter; flags a slot that must carry a stuffed 0
module usb_nrzi_stuffer
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [1:0] line_next,
  output logic       stuff_insert
);

  logic       level_j;
  logic [2:0] ones_cnt;
  logic       cur_j;
  logic [2:0] ones_base;
  logic       next_j;

  // restart starts a packet from J with no history, so SYNC always begins cleanly
  always_comb begin
    cur_j        = restart ? 1'b1 : level_j;
    ones_base    = restart ? 3'd0 : ones_cnt;
    stuff_insert = (ones_base == 3'(STUFF_LIMIT));
    next_j       = (stuff_insert || !bit_in) ? !cur_j : cur_j;
    line_next    = next_j ? LS_J : LS_K;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_j  <= 1'b1;
      ones_cnt <= 3'd0;
    end else if (bit_en) begin
      level_j <= next_j;
      if (stuff_insert || !bit_in) ones_cnt <= 3'd0;
      else                         ones_cnt <= ones_base + 3'd1;
    end
  end

endmodule

// File: rtl/usb_host_tx_phy.sv
// rtl/usb_host_tx_phy.sv - full-speed USB host transmit PHY: SYNC, stuffed NRZI data, EOP, gap
module usb_host_tx_phy
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 2
) (
  input  logic       clk48_host,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       usb_d_p_o,
  output logic       usb_d_n_o,
  output logic       usb_oe,
  output logic       busy,
  output logic       err_underrun
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e     state;
  logic [TW-1:0] bit_tmr;
  logic [3:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          last_r;
  logic [7:0]    hold_data;
  logic          hold_last;
  logic          hold_full;
  logic [1:0]    line_r;
  logic          oe_r;
  logic          busy_r;
  logic          err_r;

  logic       accept;
  logic       boundary;
  logic       start_pkt;
  logic       bit_en;
  logic       bit_in;
  logic       load;
  logic       end_pkt;
  logic       underrun;
  logic       stuff_insert;
  logic [1:0] line_next;

  assign accept   = tx_valid && !hold_full;
  assign boundary = (bit_tmr == TW'(CLKS_PER_BIT - 1));

  // A byte waiting at the end of GAP starts its SYNC straight away, keeping the gap exact
  assign start_pkt = hold_full &&
                     ((state == ST_IDLE) ||
                      (state == ST_GAP && boundary && bit_idx == 4'(GAP_BITS - 1)));

  // bit_idx is the next shift_reg bit to send; bit 3 set means the byte is exhausted
  always_comb begin
    bit_en   = 1'b0;
    bit_in   = 1'b1;
    load     = 1'b0;
    end_pkt  = 1'b0;
    underrun = 1'b0;
    if (start_pkt) begin
      bit_en = 1'b1;
      bit_in = SYNC_BYTE[0];
    end else if ((state == ST_SYNC || state == ST_DATA) && boundary) begin
      if (stuff_insert) begin
        bit_en = 1'b1;
      end else if (!bit_idx[3]) begin
        bit_en = 1'b1;
        bit_in = shift_reg[bit_idx[2:0]];
      end else if (!last_r && hold_full) begin
        load   = 1'b1;
        bit_en = 1'b1;
        bit_in = hold_data[0];
      end else begin
        end_pkt  = 1'b1;
        underrun = !last_r;
      end
    end
  end

  usb_nrzi_stuffer u_stuffer (
    .clk          (clk48_host),
    .rst_n        (reset_n),
    .restart      (start_pkt),
    .bit_en       (bit_en),
    .bit_in       (bit_in),
    .line_next    (line_next),
    .stuff_insert (stuff_insert)
  );

  always_ff @(posedge clk48_host or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_tmr   <= '0;
      bit_idx   <= 4'd0;
      shift_reg <= 8'h00;
      last_r    <= 1'b0;
      hold_data <= 8'h00;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      line_r    <= LS_J;
      oe_r      <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      err_r <= underrun;

      if (accept) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
        busy_r    <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (state == ST_IDLE || start_pkt) bit_tmr <= '0;
      else if (boundary)                 bit_tmr <= '0;
      else                               bit_tmr <= bit_tmr + TW'(1);

      if (start_pkt) begin
        state     <= ST_SYNC;
        shift_reg <= SYNC_BYTE;
        bit_idx   <= 4'd1;
        last_r    <= 1'b0;
        oe_r      <= 1'b1;
        line_r    <= line_next;
      end else if (boundary) begin
        case (state)
          ST_SYNC, ST_DATA: begin
            if (bit_en) line_r <= line_next;
            if (load) begin
              state     <= ST_DATA;
              shift_reg <= hold_data;
              last_r    <= hold_last;
              bit_idx   <= 4'd1;
            end else if (end_pkt) begin
              state   <= ST_EOP_SE0;
              line_r  <= LS_SE0;
              bit_idx <= 4'd0;
            end else if (!stuff_insert) begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
          ST_EOP_SE0: begin
            if (bit_idx[0]) begin
              state  <= ST_EOP_J;
              line_r <= LS_J;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
          ST_EOP_J: begin
            state   <= ST_GAP;
            oe_r    <= 1'b0;
            bit_idx <= 4'd0;
          end
          ST_GAP: begin
            if (bit_idx == 4'(GAP_BITS - 1)) begin
              state  <= ST_IDLE;
              busy_r <= accept;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tx_ready     = !hold_full;
  assign usb_d_p_o    = line_r[1];
  assign usb_d_n_o    = line_r[0];
  assign usb_oe       = oe_r;
  assign busy         = busy_r;
  assign err_underrun = err_r;

endmodule

// File: tb/tb_usb_host_tx_phy.sv
// tb/tb_usb_host_tx_phy.sv - scoreboard bench for the USB host transmit PHY
module tb_usb_host_tx_phy;

  localparam int CPB = 4;
  localparam int GAP = 2;

  logic       clk48_host = 1'b0;
  logic       reset_n    = 1'b0;
  logic [7:0] tx_data    = 8'h00;
  logic       tx_last    = 1'b0;
  logic       tx_valid   = 1'b0;
  logic       tx_ready;
  logic       usb_d_p_o;
  logic       usb_d_n_o;
  logic       usb_oe;
  logic       busy;
  logic       err_underrun;

  always #5 clk48_host = ~clk48_host;

  usb_host_tx_phy #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
    .clk48_host   (clk48_host),
    .reset_n      (reset_n),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .usb_d_p_o    (usb_d_p_o),
    .usb_d_n_o    (usb_d_n_o),
    .usb_oe       (usb_oe),
    .busy         (busy),
    .err_underrun (err_underrun)
  );

  typedef struct {
    string sym;
    int    errs;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks  = 0;
  int    n_pass    = 0;
  int    err_total = 0;
  string sync_s    = "KJKJKJKK";

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic check_str(input string name, input string act, input string req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  function automatic string line_sym(input logic p, input logic n);
    case ({p, n})
      2'b10:   return "J";
      2'b01:   return "K";
      2'b00:   return "0";
      default: return "X";
    endcase
  endfunction

  // One symbol per bit time in, one symbol per clock out
  function automatic string expand(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      for (int k = 0; k < CPB; k++)
        r = {r, s.substr(i, i)};
    return r;
  endfunction

  task automatic push_pkt(input string bits, input int errs);
    exp_t e;
    e.sym  = expand(bits);
    e.errs = errs;
    exp_q.push_back(e);
  endtask

  task automatic finish_pkt(input string got, input int errs, input int gap, input bit gap_j);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_packet: got %s, expected none", got);
      return;
    end
    e = exp_q.pop_front();
    check_str("line_seq", got, e.sym);
    check("oe_clks", got.len(), e.sym.len());
    check("underruns", errs, e.errs);
    check("gap_clks", gap, GAP * CPB);
    check("gap_line_j", int'(gap_j), 1);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int n, input bit mark_last);
    logic [7:0] bs [3];
    bs[0] = b0;
    bs[1] = b1;
    bs[2] = b2;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      @(negedge clk48_host);
      tx_data  = bs[i];
      tx_last  = mark_last && (i == n - 1);
      tx_valid = 1'b1;
      while (!tx_ready && w < 4000) begin
        @(negedge clk48_host);
        w++;
      end
      if (!tx_ready) begin
        n_checks++;
        $display("FAIL handshake_timeout: got tx_ready=0, expected 1");
        tx_valid = 1'b0;
        return;
      end
      @(posedge clk48_host);
      #1;
    end
    tx_valid = 1'b0;
  endtask

  task automatic check_latency();
    @(negedge clk48_host);
    check("lat_accept_oe", int'(usb_oe), 0);
    check("lat_ready_full", int'(tx_ready), 0);
    @(negedge clk48_host);
    check("lat_sync_oe", int'(usb_oe), 1);
  endtask

  task automatic drain(input string name);
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 5000) begin
      @(negedge clk48_host);
      w++;
    end
    n_checks++;
    if (exp_q.size() == 0 && !busy) n_pass++;
    else $display("FAIL drain_%s: got pending=%0d busy=%0b, expected 0 0", name, exp_q.size(), busy);
    repeat (3) @(negedge clk48_host);
  endtask

  initial begin : monitor
    string cur    = "";
    int    errs   = 0;
    int    gap    = 0;
    bit    in_pkt = 1'b0;
    bit    in_gap = 1'b0;
    bit    gap_j  = 1'b1;
    forever begin
      @(negedge clk48_host);
      if (err_underrun) err_total++;
      if (!reset_n) begin
        cur    = "";
        errs   = 0;
        in_pkt = 1'b0;
        in_gap = 1'b0;
      end else begin
        if (in_gap && (usb_oe || !busy || gap > 200)) begin
          finish_pkt(cur, errs, gap, gap_j);
          cur    = "";
          errs   = 0;
          in_gap = 1'b0;
        end
        if (usb_oe) begin
          in_pkt = 1'b1;
          cur    = {cur, line_sym(usb_d_p_o, usb_d_n_o)};
          if (err_underrun) errs++;
        end else begin
          if (in_pkt) begin
            in_pkt = 1'b0;
            in_gap = 1'b1;
            gap    = 0;
            gap_j  = 1'b1;
          end
          if (in_gap) begin
            gap++;
            if (!(usb_d_p_o && !usb_d_n_o)) gap_j = 1'b0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int w;
    repeat (3) @(negedge clk48_host);
    check("rst_oe", int'(usb_oe), 0);
    check("rst_dp", int'(usb_d_p_o), 1);
    check("rst_dn", int'(usb_d_n_o), 0);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err_underrun), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk48_host);

    push_pkt({sync_s, "KJJKJJKK00J"}, 0);
    send_pkt(8'hA5, 8'h00, 8'h00, 1, 1'b1);
    check_latency();
    drain("single_a5");

    push_pkt({sync_s, "KKKKKJJJJJJJKKKKKK00J"}, 0);
    send_pkt(8'hFF, 8'hFF, 8'h00, 2, 1'b1);
    drain("stuff_ff");

    push_pkt({sync_s, "KJKJKJKJ", "KKJKJKJK", "KKJKJKJK", "00J"}, 0);
    send_pkt(8'h01, 8'h02, 8'h03, 3, 1'b1);
    drain("three_bytes");

    push_pkt({sync_s, "KJKJJKJK00J"}, 1);
    send_pkt(8'h11, 8'h00, 8'h00, 1, 1'b0);
    drain("underrun");

    push_pkt({sync_s, "JKJKJKJK00J"}, 0);
    push_pkt({sync_s, "JJJJJJJKJ00J"}, 0);
    send_pkt(8'h00, 8'h00, 8'h00, 1, 1'b1);
    send_pkt(8'h7E, 8'h00, 8'h00, 1, 1'b1);
    drain("back_to_back");

    send_pkt(8'hA5, 8'h00, 8'h00, 1, 1'b1);
    w = 0;
    while (!usb_oe && w < 100) begin
      @(negedge clk48_host);
      w++;
    end
    repeat (40) @(negedge clk48_host);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_oe", int'(usb_oe), 0);
    check("abort_dp", int'(usb_d_p_o), 1);
    check("abort_dn", int'(usb_d_n_o), 0);
    check("abort_ready", int'(tx_ready), 1);
    check("abort_busy", int'(busy), 0);
    repeat (3) @(negedge clk48_host);
    reset_n = 1'b1;
    repeat (2) @(negedge clk48_host);

    push_pkt({sync_s, "KJJKJJKK00J"}, 0);
    send_pkt(8'hA5, 8'h00, 8'h00, 1, 1'b1);
    check_latency();
    drain("after_reset");

    check("err_pulses_total", err_total, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
